irq_ctrl_stack: RTL and testbench
=================================

Name: irq_ctrl_stack

Overview:
Parametrised, nesting-capable interrupt controller that sits beside the execute stage and generalises its single-line IRQ path.
- Latches NUM_IRQ request lines into level- or edge-mode pending bits, applies a mask, and selects the highest-priority request (lowest index).
- Presents a request and vector to execute.
- Keeps a STACK_DEPTH-deep stack of {return PC, previous active level} so higher-priority interrupts can pre-empt running handlers.
- Configuration and status are exposed on the special-register bus.

Parameters:
RW, 16, datapath / PC / sreg bus width
NUM_IRQ, 8, number of interrupt lines (1..16)
STACK_DEPTH, 4, nesting depth (power of two, >=2)
VEC_BASE, 16'h0010, vector of channel 0; channel k vector = VEC_BASE + 4*k
SR_BASE, 16'h0200, base sreg address of this block

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset; asynchronous, active-low
i_irq_lines  in  NUM_IRQ  raw request lines, synchronous to i_clk
i_global_en  in  1  global IRQ enable (priv-control irq bit from execute)
o_irq_req  out  1  interrupt request to execute
o_vector  out  RW  handler address for the current request
i_irq_ack  in  1  execute takes the interrupt this cycle
i_ack_pc  in  RW  PC to save, valid with i_irq_ack
i_irt  in  1  execute retires a return-from-interrupt this cycle
o_ret_pc  out  RW  top-of-stack PC; combinational, valid while depth>0
o_stack_full  out  1  depth == STACK_DEPTH
i_sr_addr  in  RW  sreg bus address
i_sr_data  in  RW  sreg bus write data
i_sr_we  in  1  sreg bus write strobe
o_sr_data  out  RW  sreg read data; combinational, 0 outside the block's address window

Behaviour:
- Reset (async assert, sync release) sets:
  - mask = 0, edge_mode = 0, pending = 0
  - line sample flop = 0, depth = 0
  - active level = NUM_IRQ (idle), err = 0
  - o_irq_req = 0
- Sampling: i_irq_lines registered once (line_q).
  - Edge mode: pending[k] sets on line_q[k] rising (line_q & ~line_qq).
  - Level mode: pending[k] follows line_q[k]. Software-set bits hold until cleared.
- Selection:
  - cand = pending & mask.
  - sel = lowest set index of cand.
  - o_irq_req = i_global_en & |cand & (sel < active level) & ~o_stack_full.
  - o_vector = VEC_BASE + 4*sel.
  - Both are combinational from registers, so a line edge at cycle n gives o_irq_req at n+2 (line_q, then pending).
- Ack (i_irq_ack & o_irq_req):
  - push {i_ack_pc, active level}; depth += 1
  - active level = sel
  - edge mode: clear pending[sel]; level mode: untouched
  - i_irq_ack while o_irq_req=0 is ignored.
- Return (i_irt):
  - depth>0: pop; active level = popped level.
  - depth==0: o_ret_pc = 0, err sets (sticky), depth stays 0.
- Simultaneous i_irt and i_irq_ack: irt is processed, ack is ignored, and pending stays so the request re-asserts next cycle.
- Stack full: no further pre-emption. Requests wait until a return.
- Sreg map (offset from SR_BASE):
  - 0: mask (R/W)
  - 1: pending (R; write-1-to-clear)
  - 2: edge_mode (R/W)
  - 3: status {err[15], depth[11:8], active level[4:0]} (R; write any value clears err)
  - 4: soft trigger (W; 1 sets pending; reads 0)
  - Unused bits read 0.
- Same-cycle hardware set and software clear of a pending bit: set wins.
- Changing edge_mode does not alter pending.
- Reset mid-handler discards the stack and returns to idle.

Decomposition:
- Shared package/config header:
  - sreg offsets (IRQC_MASK, IRQC_PEND, IRQC_EDGE, IRQC_STAT, IRQC_SOFT)
  - vector stride
  - level width LVL_W = clog2(NUM_IRQ+1)
  - the idle-level constant
- One sub-module, irq_prio_enc: NUM_IRQ-wide lowest-index priority encoder with valid output.
- The return stack is an inline register array with a depth counter.

Test Plan:
1. Reset; mask=0x01, edge_mode=0x01, i_global_en=1; pulse line0 at cycle 10 -> o_irq_req=1 at cycle 12, o_vector=0x0010; ack with pc=0x1234 -> depth=1, pending[0]=0, status active level=0.
2. Active level 3 (ch3 handler running); raise ch5, then ch1 -> ch5 gives no request; ch1 gives request, vector=0x0014; ack pc=0x2000, then two i_irt -> o_ret_pc 0x2000, then the original PC; level returns 3, then 8.
3. STACK_DEPTH=4: nest ch7,5,3,1 -> o_stack_full=1; raise ch0 -> o_irq_req stays 0 until one i_irt, then asserts.
4. i_irt with depth 0 -> status bit15=1, o_ret_pc=0; write status -> err=0.
5. Same cycle: i_irq_ack and i_irt -> pop only; pending bit kept; o_irq_req re-asserts next cycle.
6. Level ch2 held high through ack -> pending stays 1; software W1C on pending[2] in the same cycle as a line-high sample -> bit reads 1; asserting i_rst_n low mid-handler -> depth=0, active level=8, o_irq_req=0 immediately.

Source files
------------

// File: rtl/irq_ctrl_stack_pkg.sv
// Shared definitions for the nesting interrupt controller: special-register
// offsets, vector stride, status field positions and level-width helpers.
package irq_ctrl_stack_pkg;

  // Special-register offsets relative to the block's base address.
  typedef enum logic [2:0] {
    IRQC_MASK = 3'd0,
    IRQC_PEND = 3'd1,
    IRQC_EDGE = 3'd2,
    IRQC_STAT = 3'd3,
    IRQC_SOFT = 3'd4
  } irqc_reg_e;

  localparam int IRQC_NUM_REGS = 5;

  // Handler vectors are spaced this many address units apart.
  localparam int IRQC_VEC_STRIDE = 4;

  // Status word layout.
  localparam int IRQC_STAT_ERR_BIT   = 15;
  localparam int IRQC_STAT_DEPTH_LSB = 8;

  // Active level must encode 0..NUM_IRQ, with NUM_IRQ meaning idle.
  function automatic int irqc_lvl_w(input int num_irq);
    return $clog2(num_irq + 1);
  endfunction

  // The idle level sits one above the lowest-priority channel, so any
  // channel can pre-empt it.
  function automatic int irqc_idle_lvl(input int num_irq);
    return num_irq;
  endfunction

endpackage

// File: rtl/irq_ctrl_stack_prio_enc.sv
// Lowest-index-wins priority encoder with a valid flag.
module irq_prio_enc
  import irq_ctrl_stack_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     i_req,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // (which would infer a latch).
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = IDX_W'(i);
    end
    o_valid = |i_req;
  end

endmodule

// File: rtl/irq_ctrl_stack.sv
// Nesting interrupt controller: pending/mask/edge-mode registers, priority
// selection against the running handler's level, and a return stack of
// {PC, previous level} so higher-priority requests can pre-empt handlers.
module irq_ctrl_stack
  import irq_ctrl_stack_pkg::*;
#(
  parameter int             RW          = 16,
  parameter int             NUM_IRQ     = 8,
  parameter int             STACK_DEPTH = 4,
  parameter logic [RW-1:0]  VEC_BASE    = 16'h0010,
  parameter logic [RW-1:0]  SR_BASE     = 16'h0200
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_IRQ-1:0] i_irq_lines,
  input  logic               i_global_en,
  output logic               o_irq_req,
  output logic [RW-1:0]      o_vector,
  input  logic               i_irq_ack,
  input  logic [RW-1:0]      i_ack_pc,
  input  logic               i_irt,
  output logic [RW-1:0]      o_ret_pc,
  output logic               o_stack_full,
  input  logic [RW-1:0]      i_sr_addr,
  input  logic [RW-1:0]      i_sr_data,
  input  logic               i_sr_we,
  output logic [RW-1:0]      o_sr_data
);

  localparam int               LVL_W    = irqc_lvl_w(NUM_IRQ);
  localparam logic [LVL_W-1:0] IDLE_LVL = LVL_W'(irqc_idle_lvl(NUM_IRQ));
  localparam int               DEP_W    = $clog2(STACK_DEPTH + 1);
  localparam int               PTR_W    = $clog2(STACK_DEPTH);

  // Architectural state.
  logic [NUM_IRQ-1:0] line_q, line_qq;
  logic [NUM_IRQ-1:0] pending, pending_d;
  logic [NUM_IRQ-1:0] soft_q, soft_d;
  logic [NUM_IRQ-1:0] mask, edge_mode;
  logic [DEP_W-1:0]   depth;
  logic [LVL_W-1:0]   active_lvl;
  logic               err;

  // Return stack storage.
  logic [RW-1:0]    stack_pc  [STACK_DEPTH];
  logic [LVL_W-1:0] stack_lvl [STACK_DEPTH];

  // Selection.
  logic [NUM_IRQ-1:0] cand;
  logic [LVL_W-1:0]   sel;
  logic               cand_any;
  logic [NUM_IRQ-1:0] sel_onehot;
  logic               take, pop;
  logic [NUM_IRQ-1:0] ack_clr;
  logic [PTR_W-1:0]   push_ptr, top_ptr;

  // Special-register decode.
  logic [RW-1:0]      sr_off;
  logic               in_win;
  irqc_reg_e          reg_sel;
  logic               wr_mask, wr_pend, wr_edge, wr_stat, wr_soft;
  logic [NUM_IRQ-1:0] sr_wdata;
  logic [NUM_IRQ-1:0] w1c, soft_set;
  logic [RW-1:0]      stat_word;
  logic               sr_data_unused;

  assign cand = pending & mask;

  irq_prio_enc #(
    .N     (NUM_IRQ),
    .IDX_W (LVL_W)
  ) u_prio_enc (
    .i_req   (cand),
    .o_idx   (sel),
    .o_valid (cand_any)
  );

  assign o_stack_full = (depth == DEP_W'(STACK_DEPTH));
  assign o_irq_req    = i_global_en & cand_any & (sel < active_lvl) & ~o_stack_full;
  assign o_vector     = VEC_BASE + RW'(sel) * RW'(IRQC_VEC_STRIDE);

  // A return takes priority over an ack in the same cycle; the ack is dropped
  // and the request stays pending so it re-presents afterwards.
  assign take       = i_irq_ack & o_irq_req & ~i_irt;
  assign pop        = i_irt & (depth != '0);
  assign sel_onehot = NUM_IRQ'(1) << sel;
  assign ack_clr    = take ? (edge_mode & sel_onehot) : '0;
  assign push_ptr   = depth[PTR_W-1:0];
  assign top_ptr    = PTR_W'(depth - DEP_W'(1));
  assign o_ret_pc   = (depth != '0) ? stack_pc[top_ptr] : '0;

  assign sr_off   = i_sr_addr - SR_BASE;
  assign in_win   = (i_sr_addr >= SR_BASE) && (sr_off < RW'(IRQC_NUM_REGS));
  assign reg_sel  = irqc_reg_e'(sr_off[2:0]);
  assign wr_mask  = i_sr_we & in_win & (reg_sel == IRQC_MASK);
  assign wr_pend  = i_sr_we & in_win & (reg_sel == IRQC_PEND);
  assign wr_edge  = i_sr_we & in_win & (reg_sel == IRQC_EDGE);
  assign wr_stat  = i_sr_we & in_win & (reg_sel == IRQC_STAT);
  assign wr_soft  = i_sr_we & in_win & (reg_sel == IRQC_SOFT);
  assign sr_wdata = i_sr_data[NUM_IRQ-1:0];

  // Upper write-data bits beyond NUM_IRQ carry no meaning for this block.
  assign sr_data_unused = ^i_sr_data;

  // Sample the raw lines and keep one more stage for rising-edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      line_q  <= '0;
      line_qq <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      line_q  <= i_irq_lines;
      line_qq <= line_q;
    end
  end

  // Software-writable configuration.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mask      <= '0;
      edge_mode <= '0;
    end else begin
      if (wr_mask) mask      <= sr_wdata;
      if (wr_edge) edge_mode <= sr_wdata;
    end
  end

  // Next pending: edge channels latch rises until acked or cleared; level
  // channels track the sampled line plus any software-set bit. Sets are
  // OR-ed in last so a same-cycle set beats a clear.
  always_comb begin
    w1c       = wr_pend ? sr_wdata : '0;
    soft_set  = wr_soft ? sr_wdata : '0;
    soft_d    = (soft_q & ~w1c & ~ack_clr) | soft_set;
    pending_d = (edge_mode & ((pending & ~w1c & ~ack_clr) | (line_q & ~line_qq) | soft_set))
              | (~edge_mode & (line_q | soft_d));
  end

  // Pending bits and the record of software-set bits.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pending <= '0;
      soft_q  <= '0;
    end else begin
      pending <= pending_d;
      soft_q  <= soft_d;
    end
  end

  // Nesting control: depth, running level and the sticky underflow flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      depth      <= '0;
      active_lvl <= IDLE_LVL;
      err        <= 1'b0;
    end else begin
      if (pop) begin
        depth      <= depth - DEP_W'(1);
        active_lvl <= stack_lvl[top_ptr];
      end else if (take) begin
        depth      <= depth + DEP_W'(1);
        active_lvl <= sel;
      end
      if (i_irt && depth == '0) err <= 1'b1;
      else if (wr_stat)         err <= 1'b0;
    end
  end

  // Push the interrupted PC and level on acceptance.
  always_ff @(posedge i_clk) begin
    // NOTE: stack storage is deliberately not reset; depth qualifies every
    // entry, so stale contents are never observed.
    if (take) begin
      stack_pc[push_ptr]  <= i_ack_pc;
      stack_lvl[push_ptr] <= active_lvl;
    end
  end

  // Assemble the status word and mux the special-register read data.
  always_comb begin
    stat_word                                   = '0;
    stat_word[IRQC_STAT_ERR_BIT]                = err;
    stat_word[IRQC_STAT_DEPTH_LSB +: DEP_W]     = depth;
    stat_word[LVL_W-1:0]                        = active_lvl;

    o_sr_data = '0;
    if (in_win) begin
      case (reg_sel)
        IRQC_MASK: o_sr_data[NUM_IRQ-1:0] = mask;
        IRQC_PEND: o_sr_data[NUM_IRQ-1:0] = pending;
        IRQC_EDGE: o_sr_data[NUM_IRQ-1:0] = edge_mode;
        IRQC_STAT: o_sr_data              = stat_word;
        default:   o_sr_data              = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl_stack.sv
// Directed bench for irq_ctrl_stack with default parameters.
module tb_irq_ctrl_stack;

  localparam logic [15:0] SR_BASE = 16'h0200;
  localparam logic [2:0]  R_MASK = 3'd0, R_PEND = 3'd1, R_EDGE = 3'd2,
                          R_STAT = 3'd3, R_SOFT = 3'd4;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [7:0]  i_irq_lines = '0;
  logic        i_global_en = 1'b0;
  logic        o_irq_req;
  logic [15:0] o_vector;
  logic        i_irq_ack = 1'b0;
  logic [15:0] i_ack_pc = '0;
  logic        i_irt = 1'b0;
  logic [15:0] o_ret_pc;
  logic        o_stack_full;
  logic [15:0] i_sr_addr = '0;
  logic [15:0] i_sr_data = '0;
  logic        i_sr_we = 1'b0;
  logic [15:0] o_sr_data;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] rd;

  irq_ctrl_stack dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_irq_lines  (i_irq_lines),
    .i_global_en  (i_global_en),
    .o_irq_req    (o_irq_req),
    .o_vector     (o_vector),
    .i_irq_ack    (i_irq_ack),
    .i_ack_pc     (i_ack_pc),
    .i_irt        (i_irt),
    .o_ret_pc     (o_ret_pc),
    .o_stack_full (o_stack_full),
    .i_sr_addr    (i_sr_addr),
    .i_sr_data    (i_sr_data),
    .i_sr_we      (i_sr_we),
    .o_sr_data    (o_sr_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic pulse(input int k);
    i_irq_lines[k] = 1'b1;
    tick();
    i_irq_lines[k] = 1'b0;
    tick();
  endtask

  task automatic sr_wr(input logic [2:0] off, input logic [15:0] d);
    i_sr_addr = SR_BASE + {13'b0, off};
    i_sr_data = d;
    i_sr_we   = 1'b1;
    tick();
    i_sr_we   = 1'b0;
  endtask

  task automatic sr_rd(input logic [2:0] off, output logic [15:0] d);
    i_sr_addr = SR_BASE + {13'b0, off};
    #1;
    d = o_sr_data;
  endtask

  task automatic ack(input logic [15:0] pc);
    i_irq_ack = 1'b1;
    i_ack_pc  = pc;
    tick();
    i_irq_ack = 1'b0;
  endtask

  task automatic irt();
    i_irt = 1'b1;
    tick();
    i_irt = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    tick();
    tick();
    n_tests++; if (o_irq_req !== 1'b0) begin $display("FAIL rst_req: got %b exp 0", o_irq_req); n_fail++; end
    n_tests++; if (o_stack_full !== 1'b0) begin $display("FAIL rst_full: got %b exp 0", o_stack_full); n_fail++; end
    sr_rd(R_STAT, rd);
    n_tests++; if (rd !== 16'h0008) begin $display("FAIL rst_stat: got %h exp 0008", rd); n_fail++; end
    sr_rd(R_MASK, rd);
    n_tests++; if (rd !== 16'h0000) begin $display("FAIL rst_mask: got %h exp 0000", rd); n_fail++; end
    i_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_edge();
    sr_wr(R_MASK, 16'h0001);
    sr_wr(R_EDGE, 16'h0001);
    i_global_en = 1'b1;
    repeat (3) tick();
    i_irq_lines[0] = 1'b1;
    tick();
    i_irq_lines[0] = 1'b0;
    n_tests++; if (o_irq_req !== 1'b0) begin $display("FAIL t1_req_n1: got %b exp 0", o_irq_req); n_fail++; end
    tick();
    n_tests++; if (o_irq_req !== 1'b1) begin $display("FAIL t1_req_n2: got %b exp 1", o_irq_req); n_fail++; end
    n_tests++; if (o_vector !== 16'h0010) begin $display("FAIL t1_vec: got %h exp 0010", o_vector); n_fail++; end
    ack(16'h1234);
    sr_rd(R_STAT, rd);
    n_tests++; if (rd !== 16'h0100) begin $display("FAIL t1_stat: got %h exp 0100", rd); n_fail++; end
    sr_rd(R_PEND, rd);
    n_tests++; if (rd !== 16'h0000) begin $display("FAIL t1_pend: got %h exp 0000", rd); n_fail++; end
    n_tests++; if (o_ret_pc !== 16'h1234) begin $display("FAIL t1_retpc: got %h exp 1234", o_ret_pc); n_fail++; end
    irt();
    sr_rd(R_STAT, rd);
    n_tests++; if (rd !== 16'h0008) begin $display("FAIL t1_stat_ret: got %h exp 0008", rd); n_fail++; end
  endtask

  task automatic test_preempt();
    sr_wr(R_MASK, 16'h00FF);
    sr_wr(R_EDGE, 16'h00FF);
    pulse(3);
    n_tests++; if (o_vector !== 16'h001C) begin $display("FAIL t2_vec3: got %h exp 001c", o_vector); n_fail++; end
    ack(16'h1000);
    sr_rd(R_STAT, rd);
    n_tests++; if (rd !== 16'h0103) begin $display("FAIL t2_stat3: got %h exp 0103", rd); n_fail++; end
    pulse(5);
    n_tests++; if (o_irq_req !== 1'b0) begin $display("FAIL t2_req5: got %b exp 0", o_irq_req); n_fail++; end
    pulse(1);
    n_tests++; if (o_irq_req !== 1'b1) begin $display("FAIL t2_req1: got %b exp 1", o_irq_req); n_fail++; end
    n_tests++; if (o_vector !== 16'h0014) begin $display("FAIL t2_vec1: got %h exp 0014", o_vector); n_fail++; end
    ack(16'h2000);
    sr_rd(R_STAT, rd);
    n_tests++; if (rd !== 16'h0201) begin $display("FAIL t2_stat1: got %h exp 0201", rd); n_fail++; end
    n_tests++; if (o_ret_pc !== 16'h2000) begin $display("FAIL t2_retpc1: got %h exp 2000", o_ret_pc); n_fail++; end
    irt();
    n_tests++; if (o_ret_pc !== 16'h1000) begin $display("FAIL t2_retpc2: got %h exp 1000", o_ret_pc); n_fail++; end
    sr_rd(R_STAT, rd);
    n_tests++; if (rd !== 16'h0103) begin $display("FAIL t2_stat_pop1: got %h exp 0103", rd); n_fail++; end
    n_tests++; if (o_irq_req !== 1'b0) begin $display("FAIL t2_req_lvl3: got %b exp 0", o_irq_req); n_fail++; end
    irt();
    sr_rd(R_STAT, rd);
    n_tests++; if (rd !== 16'h0008) begin $display("FAIL t2_stat_pop2: got %h exp 0008", rd); n_fail++; end
    n_tests++; if (o_irq_req !== 1'b1 || o_vector !== 16'h0024) begin
      $display("FAIL t2_req5_idle: got req=%b vec=%h exp req=1 vec=0024", o_irq_req, o_vector); n_fail++; end
    sr_wr(R_PEND, 16'h0020);
    sr_rd(R_PEND, rd);
    n_tests++; if (rd !== 16'h0000) begin $display("FAIL t2_w1c: got %h exp 0000", rd); n_fail++; end
  endtask

  task automatic test_stack_full();
    pulse(7); ack(16'h3007);
    pulse(5); ack(16'h3005);
    pulse(3); ack(16'h3003);
    pulse(1); ack(16'h3001);
    n_tests++; if (o_stack_full !== 1'b1) begin $display("FAIL t3_full: got %b exp 1", o_stack_full); n_fail++; end
    sr_rd(R_STAT, rd);
    n_tests++; if (rd !== 16'h0401) begin $display("FAIL t3_stat_full: got %h exp 0401", rd); n_fail++; end
    pulse(0);
    tick();
    n_tests++; if (o_irq_req !== 1'b0) begin $display("FAIL t3_req_full: got %b exp 0", o_irq_req); n_fail++; end
    irt();
    n_tests++; if (o_stack_full !== 1'b0) begin $display("FAIL t3_notfull: got %b exp 0", o_stack_full); n_fail++; end
    n_tests++; if (o_irq_req !== 1'b1 || o_vector !== 16'h0010) begin
      $display("FAIL t3_req0: got req=%b vec=%h exp req=1 vec=0010", o_irq_req, o_vector); n_fail++; end
    ack(16'h3000);
    irt();
    n_tests++; if (o_ret_pc !== 16'h3003) begin $display("FAIL t3_retpc: got %h exp 3003", o_ret_pc); n_fail++; end
    irt(); irt(); irt();
    sr_rd(R_STAT, rd);
    n_tests++; if (rd !== 16'h0008) begin $display("FAIL t3_unwind: got %h exp 0008", rd); n_fail++; end
  endtask

  task automatic test_underflow_soft();
    irt();
    sr_rd(R_STAT, rd);
    n_tests++; if (rd !== 16'h8008) begin $display("FAIL t4_err: got %h exp 8008", rd); n_fail++; end
    n_tests++; if (o_ret_pc !== 16'h0000) begin $display("FAIL t4_retpc: got %h exp 0000", o_ret_pc); n_fail++; end
    sr_wr(R_STAT, 16'h1234);
    sr_rd(R_STAT, rd);
    n_tests++; if (rd !== 16'h0008) begin $display("FAIL t4_errclr: got %h exp 0008", rd); n_fail++; end
    sr_wr(R_SOFT, 16'h0008);
    sr_rd(R_PEND, rd);
    n_tests++; if (rd !== 16'h0008) begin $display("FAIL t4_soft_pend: got %h exp 0008", rd); n_fail++; end
    sr_rd(R_SOFT, rd);
    n_tests++; if (rd !== 16'h0000) begin $display("FAIL t4_soft_rd: got %h exp 0000", rd); n_fail++; end
    n_tests++; if (o_irq_req !== 1'b1 || o_vector !== 16'h001C) begin
      $display("FAIL t4_soft_req: got req=%b vec=%h exp req=1 vec=001c", o_irq_req, o_vector); n_fail++; end
    sr_wr(R_PEND, 16'h0008);
    sr_rd(R_PEND, rd);
    n_tests++; if (rd !== 16'h0000) begin $display("FAIL t4_soft_clr: got %h exp 0000", rd); n_fail++; end
  endtask

  task automatic test_ack_irt_same();
    pulse(6);
    ack(16'h5006);
    pulse(2);
    n_tests++; if (o_vector !== 16'h0018) begin $display("FAIL t5_vec: got %h exp 0018", o_vector); n_fail++; end
    i_irq_ack = 1'b1;
    i_ack_pc  = 16'h5002;
    i_irt     = 1'b1;
    tick();
    i_irq_ack = 1'b0;
    i_irt     = 1'b0;
    sr_rd(R_STAT, rd);
    n_tests++; if (rd !== 16'h0008) begin $display("FAIL t5_stat: got %h exp 0008", rd); n_fail++; end
    sr_rd(R_PEND, rd);
    n_tests++; if (rd !== 16'h0004) begin $display("FAIL t5_pend: got %h exp 0004", rd); n_fail++; end
    n_tests++; if (o_irq_req !== 1'b1) begin $display("FAIL t5_req: got %b exp 1", o_irq_req); n_fail++; end
    ack(16'h5002);
    sr_rd(R_STAT, rd);
    n_tests++; if (rd !== 16'h0102) begin $display("FAIL t5_stat_ack: got %h exp 0102", rd); n_fail++; end
    irt();
  endtask

  task automatic test_level_reset();
    sr_wr(R_EDGE, 16'h00FB);
    i_irq_lines[2] = 1'b1;
    tick();
    tick();
    n_tests++; if (o_irq_req !== 1'b1 || o_vector !== 16'h0018) begin
      $display("FAIL t6_req: got req=%b vec=%h exp req=1 vec=0018", o_irq_req, o_vector); n_fail++; end
    ack(16'h6000);
    sr_rd(R_PEND, rd);
    n_tests++; if (rd !== 16'h0004) begin $display("FAIL t6_pend_ack: got %h exp 0004", rd); n_fail++; end
    sr_wr(R_PEND, 16'h0004);
    sr_rd(R_PEND, rd);
    n_tests++; if (rd !== 16'h0004) begin $display("FAIL t6_setwins: got %h exp 0004", rd); n_fail++; end
    sr_rd(R_STAT, rd);
    n_tests++; if (rd !== 16'h0102) begin $display("FAIL t6_stat_pre: got %h exp 0102", rd); n_fail++; end
    i_rst_n = 1'b0;
    #1;
    n_tests++; if (o_irq_req !== 1'b0) begin $display("FAIL t6_rst_req: got %b exp 0", o_irq_req); n_fail++; end
    sr_rd(R_STAT, rd);
    n_tests++; if (rd !== 16'h0008) begin $display("FAIL t6_rst_stat: got %h exp 0008", rd); n_fail++; end
    n_tests++; if (o_ret_pc !== 16'h0000) begin $display("FAIL t6_rst_retpc: got %h exp 0000", o_ret_pc); n_fail++; end
    i_irq_lines[2] = 1'b0;
    tick();
    i_rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic_edge();
    test_preempt();
    test_stack_full();
    test_underflow_soft();
    test_ack_irt_same();
    test_level_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
